pe_weight_feeder: RTL and testbench
===================================

# pe_weight_feeder

Host-to-PE weight source for the PE array. Accepts a per-layer configuration (mode, bypass) and a weight stream from the host over a valid/ready handshake, and stores up to 16 weights in a local buffer. It presents configuration and `weight_in_valid` to the PE controller, then serves the controller's `weight_address` reads with one-cycle latency. It retires the load when the PE raises `interrupt`. It is the load-side counterpart of the PE controller: it drives that controller's `mod`, `bypass_control`, `ready` and `weight_in_valid` inputs and consumes its `enable`, `interrupt` and `weight_address` outputs.

## Interface
- `DATA_W`, 16, weight word width
- `DEPTH`, 16, buffer entries; fixed at 16 to match the 4-bit `weight_address`

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `cfg_start`  in  1  single-cycle pulse; latches `cfg_mod`/`cfg_bypass` and begins a load
- `cfg_mod`  in  3  layer mode, one-hot: 001 = A, 010 = B, 100 = C
- `cfg_bypass`  in  1  bypass layer; no weights loaded
- `s_valid`  in  1  host weight beat valid
- `s_ready`  out  1  feeder accepts a beat
- `s_data`  in  DATA_W  weight word
- `s_last`  in  1  final beat of the weight set
- `done`  out  1  one-cycle pulse; PE finished using the set
- `err`  out  1  sticky; `cfg_start` seen with non-one-hot `cfg_mod`
- `mod`  out  3  to PE controller `mod`
- `bypass_control`  out  1  to PE controller
- `ready`  out  1  to PE controller `ready`; buffer armed
- `weight_in_valid`  out  1  to PE controller; weight set valid
- `enable`  in  1  from PE controller; PE is running
- `interrupt`  in  1  from PE controller; PE finished
- `weight_address`  in  4  from PE controller; read index
- `weight_data`  out  DATA_W  weight read at `weight_address`

## Operation
- FSM states: IDLE, LOAD, ARMED, RUN.
- **IDLE**
  - All PE-side handshakes are low.
  - `cfg_start` with one-hot `cfg_mod`: latch `mod` and `bypass_control`, clear `wptr` and `count`.
    - If `cfg_bypass` = 0, go to LOAD.
    - If `cfg_bypass` = 1, go straight to ARMED with `count` = 0.
  - `cfg_start` with invalid `cfg_mod`: set `err`, stay in IDLE, leave `mod` unchanged.
- **LOAD**
  - `s_ready` = 1.
  - Each accepted beat (`s_valid` & `s_ready`) writes `mem[wptr]`, then increments `wptr` and `count`.
  - Leave LOAD for ARMED when the accepted beat has `s_last` = 1 or is the 16th beat (`wptr` = 15).
  - A beat accepted at `wptr` = 15 without `s_last` still completes the set; no overflow is possible.
- **ARMED**
  - `ready` = 1 and `weight_in_valid` = 1.
  - `enable` = 1 moves the FSM to RUN.
- **RUN**
  - `ready` and `weight_in_valid` stay at 1.
  - `weight_data` is registered: `mem[weight_address]` if `weight_address` < `count`, else 0. Bypass therefore always reads 0.
  - `interrupt` = 1 moves the FSM to IDLE and pulses `done`.
- `cfg_start` outside IDLE is ignored; the latched config is unchanged.
- `mod` and `bypass_control` hold their last latched values through IDLE until the next valid `cfg_start`.
- `err` clears only on reset.
- Buffer contents are not cleared between sets; the `count` gating hides stale entries.
- Reset mid-operation: the FSM returns to IDLE, all outputs return to reset values, and any partial load is discarded.

## Timing
- Reset values:
  - state IDLE
  - `s_ready` 0, `done` 0, `err` 0
  - `mod` 000, `bypass_control` 0
  - `ready` 0, `weight_in_valid` 0, `weight_data` 0
  - `wptr` 0, `count` 0
- `cfg_start` at edge N: state and latched config are updated after edge N; `s_ready` is high in cycle N+1.
- `s_ready` is decoded from the state register, not from `s_valid`.
- Final beat accepted at edge M: `s_ready` = 0 and `ready`/`weight_in_valid` = 1 from cycle M+1.
- `enable` sampled high at edge K: RUN from K+1.
- `weight_data` latency: address sampled at edge E, data valid after E, i.e. 1 cycle.
- `interrupt` sampled at edge J:
  - `done` = 1 for cycle J+1 only.
  - `ready`/`weight_in_valid` = 0 from J+1.
  - A new `cfg_start` is accepted from cycle J+1.
- Simultaneous `enable` and `interrupt` in ARMED: `enable` wins (→ RUN); `interrupt` is ignored outside RUN.
- Simultaneous `s_valid` with `s_last` at `wptr` = 15: a single write, then → ARMED.

## Test plan
- Full load:
  - `cfg_start`, `cfg_mod` = 010, 16 beats of data 0x0100+i, `s_last` on beat 16.
  - Expect `mod` = 010, `weight_in_valid` high the cycle after beat 16, and `s_ready` low.
  - Then `enable`, then sweep `weight_address` 0..15; expect `weight_data` = 0x0100+addr one cycle after each address.
- Short load:
  - 5 beats 0xA0..0xA4 with `s_last` on beat 5, with backpressure-free and randomly gapped `s_valid`.
  - Expect addr 0..4 to return 0xA0..0xA4 and addr 5..15 to return 0.
- Bypass:
  - `cfg_start` with `cfg_bypass` = 1 and `cfg_mod` = 100.
  - Expect `s_ready` never high, ARMED on the next cycle, `bypass_control` = 1, and all reads returning 0.
- Invalid mode and ignored start:
  - `cfg_mod` = 011: expect `err` = 1, state IDLE, `mod` unchanged.
  - `cfg_start` issued during LOAD: expect no effect on `wptr` or config.
- Completion and reset:
  - `interrupt` in RUN: expect a one-cycle `done` and `weight_in_valid` low next cycle; a back-to-back new load then succeeds.
  - Assert `rst` low mid-LOAD after 7 beats: expect all outputs at reset values immediately. A subsequent 3-beat load must return 0 at addr ≥ 3.

Source files
------------

// File: rtl/pe_weight_feeder.sv
// pe_weight_feeder: host-to-PE weight source. Latches per-layer config,
// buffers up to 16 weights from a valid/ready stream, arms the PE controller
// and serves its weight_address reads with one-cycle registered latency.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no set loaded; waiting for a valid cfg_start
// LOAD  | accepting host beats into the buffer (s_ready high)
// ARMED | set complete; ready/weight_in_valid high, waiting for enable
// RUN   | PE consuming weights; reads served until interrupt
module pe_weight_feeder #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [2:0]        cfg_mod,
  input  logic              cfg_bypass,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              done,
  output logic              err,
  output logic [2:0]        mod,
  output logic              bypass_control,
  output logic              ready,
  output logic              weight_in_valid,
  input  logic              enable,
  input  logic              interrupt,
  input  logic [3:0]        weight_address,
  output logic [DATA_W-1:0] weight_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          mod_q, mod_d;
  logic                bypass_q, bypass_d;
  logic                err_q, err_d;
  logic [3:0]          wptr_q, wptr_d;
  logic [4:0]          count_q, count_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   weight_data_q, weight_data_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;

  logic cfg_ok;
  logic beat;
  logic set_end;
  logic rd_hit;

  assign cfg_ok  = (cfg_mod == 3'b001) || (cfg_mod == 3'b010) || (cfg_mod == 3'b100);
  assign beat    = (state_q == ST_LOAD) && s_valid;
  // The 16th beat closes the set even without s_last, so wptr can never wrap into live data.
  assign set_end = s_last || (wptr_q == 4'd15);
  assign rd_hit  = ({1'b0, weight_address} < count_q);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start && cfg_ok) begin
          state_d = cfg_bypass ? ST_ARMED : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (beat && set_end) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (enable) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (interrupt) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded purely from the state register.
  always_comb begin
    s_ready         = (state_q == ST_LOAD);
    ready           = (state_q == ST_ARMED) || (state_q == ST_RUN);
    weight_in_valid = (state_q == ST_ARMED) || (state_q == ST_RUN);
  end

  // Config latch, write pointer/count, error flag, done pulse and read data.
  always_comb begin
    mod_d         = mod_q;
    bypass_d      = bypass_q;
    err_d         = err_q;
    wptr_d        = wptr_q;
    count_d       = count_q;
    mem_we        = 1'b0;
    done_d        = (state_q == ST_RUN) && interrupt;
    // Reads beyond the loaded count return 0 so stale entries from older sets stay hidden.
    weight_data_d = ((state_q == ST_RUN) && rd_hit) ? mem_q[weight_address] : '0;
    if (state_q == ST_IDLE && cfg_start) begin
      if (cfg_ok) begin
        mod_d    = cfg_mod;
        bypass_d = cfg_bypass;
        wptr_d   = 4'd0;
        count_d  = 5'd0;
      end else begin
        err_d = 1'b1;
      end
    end
    if (beat) begin
      mem_we  = 1'b1;
      wptr_d  = wptr_q + 4'd1;
      count_d = count_q + 5'd1;
    end
  end

  // Control/datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mod_q         <= 3'b000;
      bypass_q      <= 1'b0;
      err_q         <= 1'b0;
      wptr_q        <= 4'd0;
      count_q       <= 5'd0;
      done_q        <= 1'b0;
      weight_data_q <= '0;
    end else begin
      mod_q         <= mod_d;
      bypass_q      <= bypass_d;
      err_q         <= err_d;
      wptr_q        <= wptr_d;
      count_q       <= count_d;
      done_q        <= done_d;
      weight_data_q <= weight_data_d;
    end
  end

  // Weight buffer; not reset, count gating masks whatever it holds.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wptr_q] <= s_data;
    end
  end

  assign done           = done_q;
  assign err            = err_q;
  assign mod            = mod_q;
  assign bypass_control = bypass_q;
  assign weight_data    = weight_data_q;

endmodule

// File: tb/tb_pe_weight_feeder.sv
// Bench for pe_weight_feeder: directed test-plan sequences with literal
// expectations, then randomized traffic, all compared every cycle against a
// behavioural model of the feeder.
module tb_pe_weight_feeder;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_start = 1'b0;
  logic [2:0]        cfg_mod = 3'b000;
  logic              cfg_bypass = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_last = 1'b0;
  logic              done;
  logic              err;
  logic [2:0]        mod;
  logic              bypass_control;
  logic              ready;
  logic              weight_in_valid;
  logic              enable = 1'b0;
  logic              interrupt = 1'b0;
  logic [3:0]        weight_address = 4'd0;
  logic [DATA_W-1:0] weight_data;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  pe_weight_feeder #(.DATA_W(DATA_W), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_mod(cfg_mod),
    .cfg_bypass(cfg_bypass), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .done(done), .err(err), .mod(mod),
    .bypass_control(bypass_control), .ready(ready),
    .weight_in_valid(weight_in_valid), .enable(enable), .interrupt(interrupt),
    .weight_address(weight_address), .weight_data(weight_data)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase of the load life cycle plus a list of loaded weights.
  localparam int P_IDLE = 0, P_LOAD = 1, P_ARMED = 2, P_RUN = 3;
  int                m_phase = P_IDLE;
  logic [DATA_W-1:0] m_buf [16];
  int                m_cnt = 0;
  logic [2:0]        m_mod = 3'b000;
  logic              m_byp = 1'b0;
  logic              m_err = 1'b0;
  logic              m_done = 1'b0;
  logic [DATA_W-1:0] m_wdata = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = P_IDLE; m_cnt = 0; m_mod = 3'b000; m_byp = 1'b0;
      m_err = 1'b0; m_done = 1'b0; m_wdata = '0;
    end else begin
      m_done  = (m_phase == P_RUN) && interrupt;
      m_wdata = (m_phase == P_RUN && int'(weight_address) < m_cnt) ? m_buf[weight_address] : '0;
      case (m_phase)
        P_IDLE: if (cfg_start) begin
          if (cfg_mod == 3'd1 || cfg_mod == 3'd2 || cfg_mod == 3'd4) begin
            m_mod = cfg_mod; m_byp = cfg_bypass; m_cnt = 0;
            m_phase = cfg_bypass ? P_ARMED : P_LOAD;
          end else begin
            m_err = 1'b1;
          end
        end
        P_LOAD: if (s_valid) begin
          m_buf[m_cnt] = s_data;
          m_cnt = m_cnt + 1;
          if (s_last || m_cnt == 16) m_phase = P_ARMED;
        end
        P_ARMED: if (enable) m_phase = P_RUN;
        default: if (interrupt) m_phase = P_IDLE;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("s_ready",         32'(s_ready),         32'(m_phase == P_LOAD));
      check("ready",           32'(ready),           32'(m_phase >= P_ARMED));
      check("weight_in_valid", 32'(weight_in_valid), 32'(m_phase >= P_ARMED));
      check("mod",             32'(mod),             32'(m_mod));
      check("bypass_control",  32'(bypass_control),  32'(m_byp));
      check("err",             32'(err),             32'(m_err));
      check("done",            32'(done),            32'(m_done));
      check("weight_data",     32'(weight_data),     32'(m_wdata));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [2:0] md, input logic byp);
    cfg_start = 1'b1; cfg_mod = md; cfg_bypass = byp;
    tick();
    cfg_start = 1'b0; cfg_bypass = 1'b0;
  endtask

  task automatic beat(input logic [DATA_W-1:0] d, input logic last, input bit gaps);
    if (gaps) begin
      s_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end
    s_valid = 1'b1; s_data = d; s_last = last;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic run_and_sweep(input string name, input int n, input logic [DATA_W-1:0] base);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    for (int a = 0; a < 16; a++) begin
      weight_address = 4'(a);
      tick();
      check(name, 32'(weight_data), (a < n) ? 32'(base) + 32'(a) : 32'd0);
    end
  endtask

  task automatic finish_run();
    interrupt = 1'b1;
    tick();
    interrupt = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("wiv_after_irq", 32'(weight_in_valid), 32'd0);
  endtask

  initial begin
    #3 rst = 1'b0;
    chk_en = 1'b1;
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_wdata", 32'(weight_data), 32'd0);
    check("rst_mod", 32'(mod), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Full 16-beat load, mode B.
    start(3'b010, 1'b0);
    for (int i = 0; i < 16; i++) beat(16'h0100 + 16'(i), i == 15, 1'b0);
    check("full_mod", 32'(mod), 32'h2);
    check("full_wiv", 32'(weight_in_valid), 32'd1);
    check("full_s_ready", 32'(s_ready), 32'd0);
    run_and_sweep("full_read", 16, 16'h0100);
    finish_run();

    // Back-to-back short load with random gaps.
    start(3'b001, 1'b0);
    for (int i = 0; i < 5; i++) beat(16'h00A0 + 16'(i), i == 4, 1'b1);
    run_and_sweep("short_read", 5, 16'h00A0);
    finish_run();
    tick();
    check("done_one_cycle", 32'(done), 32'd0);

    // Bypass.
    start(3'b100, 1'b1);
    check("byp_ready", 32'(ready), 32'd1);
    check("byp_ctrl", 32'(bypass_control), 32'd1);
    check("byp_s_ready", 32'(s_ready), 32'd0);
    run_and_sweep("byp_read", 0, 16'h0000);
    finish_run();

    // Invalid mode leaves config alone and flags err.
    start(3'b011, 1'b0);
    check("inv_err", 32'(err), 32'd1);
    check("inv_mod", 32'(mod), 32'h4);
    check("inv_idle", 32'(ready | s_ready), 32'd0);

    // cfg_start during LOAD is ignored.
    start(3'b001, 1'b0);
    beat(16'h0011, 1'b0, 1'b0);
    beat(16'h0012, 1'b0, 1'b0);
    start(3'b010, 1'b1);
    check("ign_mod", 32'(mod), 32'h1);
    check("ign_byp", 32'(bypass_control), 32'd0);
    beat(16'h0013, 1'b1, 1'b0);
    run_and_sweep("ign_read", 3, 16'h0011);
    finish_run();

    // Reset mid-load after 7 beats, then a 3-beat load.
    start(3'b010, 1'b0);
    for (int i = 0; i < 7; i++) beat(16'h0700 + 16'(i), 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("mrst_s_ready", 32'(s_ready), 32'd0);
    check("mrst_err", 32'(err), 32'd0);
    check("mrst_mod", 32'(mod), 32'd0);
    check("mrst_wiv", 32'(weight_in_valid), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    start(3'b001, 1'b0);
    for (int i = 0; i < 3; i++) beat(16'h0031 + 16'(i), i == 2, 1'b0);
    run_and_sweep("post_rst_read", 3, 16'h0031);
    finish_run();

    // Randomized traffic; the per-cycle compare against the model does the checking.
    for (int c = 0; c < 4000; c++) begin
      cfg_start = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 5))
        0: cfg_mod = 3'b001;
        1: cfg_mod = 3'b010;
        2: cfg_mod = 3'b100;
        3: cfg_mod = 3'b011;
        4: cfg_mod = 3'b000;
        default: cfg_mod = 3'b010;
      endcase
      cfg_bypass     = ($urandom_range(0, 3) == 0);
      s_valid        = ($urandom_range(0, 9) < 6);
      s_data         = 16'($urandom);
      s_last         = ($urandom_range(0, 7) == 0);
      enable         = ($urandom_range(0, 4) == 0);
      interrupt      = ($urandom_range(0, 7) == 0);
      weight_address = 4'($urandom);
      rst            = ($urandom_range(0, 799) != 0);
      tick();
    end
    rst = 1'b1;
    cfg_start = 1'b0; s_valid = 1'b0; enable = 1'b0; interrupt = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
